// File: rtl/press_classifier_pkg.sv
// press_classifier_pkg: shared config for the button chain (clock, debounce and gesture timing, FSM states)
package press_classifier_pkg;

   localparam int ClkFreq     = 100_000_000;
   localparam int StableTime  = 10;
   localparam int LongPressMs = 1000;
   localparam int DoubleGapMs = 250;

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      LONG_HELD,
      WAIT_SECOND,
      SECOND_PRESSED
   } press_state_e;

   function automatic int ms_to_cycles(input int freq, input int ms);
      return freq / 1000 * ms;
   endfunction

endpackage

// File: rtl/press_classifier_edge_detect.sv
// press_classifier_edge_detect: rise/fall strobes of a level
// ports: clk_i clock, d_i level in, rise_o/fall_o combinational one-cycle edge strobes
module press_classifier_edge_detect (
   input  logic clk_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic prev_q;

   // prev_q tracks d_i every cycle including reset, so a level already high at reset release is not an edge
   always_ff @(posedge clk_i) prev_q <= d_i;

   assign rise_o = d_i & ~prev_q;
   assign fall_o = ~d_i & prev_q;

endmodule

// File: rtl/press_classifier.sv
// press_classifier: classify debounced button gestures into short/long/double one-cycle pulses
// ports: clk_i, rst_ni (sync, active low), db_level_i (1 = pressed),
//        short_press_o / long_press_o / double_press_o (registered pulses), busy_o (FSM not idle)
module press_classifier #(
   parameter int ClkFreq     = press_classifier_pkg::ClkFreq,
   parameter int LongPressMs = press_classifier_pkg::LongPressMs,
   parameter int DoubleGapMs = press_classifier_pkg::DoubleGapMs
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic db_level_i,
   output logic short_press_o,
   output logic long_press_o,
   output logic double_press_o,
   output logic busy_o
);

   import press_classifier_pkg::*;

   localparam int LongCycles = ms_to_cycles(ClkFreq, LongPressMs);
   localparam int GapCycles  = ms_to_cycles(ClkFreq, DoubleGapMs);
   localparam int MaxCycles  = LongCycles > GapCycles ? LongCycles : GapCycles;
   localparam int CntW       = $clog2(MaxCycles + 1);

   press_state_e state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic short_q, short_d, long_q, long_d, dbl_q, dbl_d, busy_q;
   logic rise, fall;

   press_classifier_edge_detect u_edge (
      .clk_i (clk_i),
      .d_i   (db_level_i),
      .rise_o(rise),
      .fall_o(fall)
   );

   // edges take priority over the timeouts in PRESSED and WAIT_SECOND
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      short_d = 1'b0;
      long_d  = 1'b0;
      dbl_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rise) state_d = PRESSED;
         end
         PRESSED: begin
            if (fall) begin
               state_d = WAIT_SECOND;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(LongCycles - 1)) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         LONG_HELD: begin
            cnt_d = '0;
            if (fall) state_d = IDLE;
         end
         WAIT_SECOND: begin
            if (rise) begin
               state_d = SECOND_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(GapCycles - 1)) begin
               state_d = IDLE;
               short_d = 1'b1;
               cnt_d   = '0;
            end
         end
         SECOND_PRESSED: begin
            cnt_d = '0;
            if (fall) begin
               state_d = IDLE;
               dbl_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         dbl_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         short_q <= short_d;
         long_q  <= long_d;
         dbl_q   <= dbl_d;
         busy_q  <= state_d != IDLE;
      end
   end

   assign short_press_o  = short_q;
   assign long_press_o   = long_q;
   assign double_press_o = dbl_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed gesture vectors plus reset corner sequences
module tb_press_classifier;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic db = 1'b0;
   logic short_o, long_o, dbl_o, busy;

   int cyc = 0;
   int n_s, n_l, n_d, n_busy, n_multi, t_first;
   int nvec = 0;
   int nfail = 0;

   typedef struct {
      int hold1;
      int gap;
      int hold2;
      int n_short;
      int n_long;
      int n_dbl;
      int ref_sel;
      int ofs;
   } vec_t;

   localparam int NV = 10;
   vec_t v [NV];

   press_classifier #(
      .ClkFreq    (1000),
      .LongPressMs(1000),
      .DoubleGapMs(250)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .db_level_i    (db),
      .short_press_o (short_o),
      .long_press_o  (long_o),
      .double_press_o(dbl_o),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (short_o) n_s++;
      if (long_o) n_l++;
      if (dbl_o) n_d++;
      if (busy) n_busy++;
      if (int'(short_o) + int'(long_o) + int'(dbl_o) > 1) n_multi++;
      if ((short_o || long_o || dbl_o) && t_first < 0) t_first = cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clr();
      n_s = 0;
      n_l = 0;
      n_d = 0;
      n_busy = 0;
      n_multi = 0;
      t_first = -1;
   endtask

   task automatic apply(input logic lvl, input int n, output int first);
      @(negedge clk);
      db = lvl;
      first = cyc + 1;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      int p, r, p2, r2, ref_t;
      v[0] = '{100,  0,   0,    1, 0, 0, 1, 251};
      v[1] = '{1500, 0,   0,    0, 1, 0, 0, 1001};
      v[2] = '{50,   100, 50,   0, 0, 1, 2, 1};
      v[3] = '{50,   250, 50,   0, 0, 1, 2, 1};
      v[4] = '{50,   251, 50,   2, 0, 0, 1, 251};
      v[5] = '{1000, 0,   0,    1, 0, 0, 1, 251};
      v[6] = '{999,  0,   0,    1, 0, 0, 1, 251};
      v[7] = '{1001, 0,   0,    0, 1, 0, 0, 1001};
      v[8] = '{50,   100, 1500, 0, 0, 1, 2, 1};
      v[9] = '{80,   249, 30,   0, 0, 1, 2, 1};
      clr();
      rst_n = 1'b0;
      db = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_short", int'(short_o), 0);
      chk("rst_long", int'(long_o), 0);
      chk("rst_double", int'(dbl_o), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;
      clr();
      repeat (2000) @(negedge clk);
      chk("held_at_reset_busy", n_busy, 0);
      chk("held_at_reset_pulses", n_s + n_l + n_d, 0);
      apply(0, 20, r);
      chk("held_release_busy", n_busy, 0);
      chk("held_release_pulses", n_s + n_l + n_d, 0);
      for (int i = 0; i < NV; i++) begin
         clr();
         r2 = 0;
         apply(1, v[i].hold1, p);
         apply(0, v[i].hold2 != 0 ? v[i].gap : 400, r);
         if (v[i].hold2 != 0) begin
            apply(1, v[i].hold2, p2);
            apply(0, 400, r2);
         end
         ref_t = v[i].ref_sel == 0 ? p : v[i].ref_sel == 1 ? r : r2;
         chk($sformatf("v%0d_short", i), n_s, v[i].n_short);
         chk($sformatf("v%0d_long", i), n_l, v[i].n_long);
         chk($sformatf("v%0d_double", i), n_d, v[i].n_dbl);
         chk($sformatf("v%0d_time", i), t_first, ref_t + v[i].ofs);
         chk($sformatf("v%0d_multi", i), n_multi, 0);
         chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
      end
      clr();
      apply(1, 1500, p);
      apply(0, 2, r);
      chk("long_release_busy", int'(busy), 0);
      chk("long_release_long", n_l, 1);
      repeat (300) @(negedge clk);
      chk("long_release_pulses", n_s + n_d, 0);
      clr();
      apply(1, 600, p);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midreset_busy", int'(busy), 0);
      n_busy = 0;
      repeat (900) @(negedge clk);
      chk("midreset_idle", n_busy, 0);
      chk("midreset_long", n_l, 0);
      apply(0, 400, r);
      chk("midreset_pulses", n_s + n_l + n_d, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
